// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: the decode slot, EX-stage kill/freeze controls, the writeback
// port and the registered EX outputs.
// The master modport drives the decode side; the slave modport is the stage itself.
interface id_ex_stage_if #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
);
  // Decode slot
  logic              id_valid;
  logic [4:0]        id_rn;
  logic [4:0]        id_rm;
  logic              id_uses_rm;
  logic [4:0]        id_rd;
  logic [63:0]       id_data1;
  logic [63:0]       id_data2;
  logic [63:0]       id_imm;
  logic              id_memread;
  logic              id_regwrite;
  logic [CTRL_W-1:0] id_ctrl;

  // EX-stage controls
  logic              ex_flush;
  logic              ex_hold;

  // Register file write port (observed for the bypass)
  logic              wb_regwrite;
  logic [4:0]        wb_reg;
  logic [63:0]       wb_data;

  // Outputs
  logic              stall_out;
  logic              ex_valid;
  logic              ex_memread;
  logic              ex_regwrite;
  logic [4:0]        ex_rn;
  logic [4:0]        ex_rm;
  logic [4:0]        ex_rd;
  logic [63:0]       ex_a;
  logic [63:0]       ex_b;
  logic [63:0]       ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_rn, id_rm, id_uses_rm, id_rd, id_data1, id_data2, id_imm,
           id_memread, id_regwrite, id_ctrl, ex_flush, ex_hold,
           wb_regwrite, wb_reg, wb_data,
    input  stall_out, ex_valid, ex_memread, ex_regwrite, ex_rn, ex_rm, ex_rd,
           ex_a, ex_b, ex_imm, ex_ctrl, bubble_cnt
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_uses_rm, id_rd, id_data1, id_data2, id_imm,
           id_memread, id_regwrite, id_ctrl, ex_flush, ex_hold,
           wb_regwrite, wb_reg, wb_data,
    output stall_out, ex_valid, ex_memread, ex_regwrite, ex_rn, ex_rm, ex_rd,
           ex_a, ex_b, ex_imm, ex_ctrl, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register sitting directly behind the register file.
// Captures operands, immediate and decode controls for EX, inserts a single
// bubble on a load-use hazard, applies branch flush and counts inserted bubbles.
// Optional macro ID_EX_WB_BYPASS_EN: forwards the same-cycle register file write
// into the captured operands, because the register file read in the write cycle
// returns the stale value. Without it, the wb_* inputs are ignored.
module id_ex_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input logic          clock,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  localparam logic [4:0] Xzr = 5'd31;

  typedef struct packed {
    logic              valid;
    logic              memread;
    logic              regwrite;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [4:0]        rd;
    logic [63:0]       a;
    logic [63:0]       b;
    logic [63:0]       imm;
    logic [CTRL_W-1:0] ctrl;
  } ex_reg_t;

  ex_reg_t          ex_q, ex_d, id_slot;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rn_hit, rm_hit, load_use;
  logic [63:0]      opnd_a, opnd_b;

  // Load-use hazard against the load currently held in EX; XZR never hazards
  always_comb begin
    rn_hit   = (ex_q.rd == bus.id_rn);
    rm_hit   = bus.id_uses_rm & (ex_q.rd == bus.id_rm);
    load_use = bus.id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != Xzr) &
               (rn_hit | rm_hit);
  end

`ifdef ID_EX_WB_BYPASS_EN
  logic wb_live;

  // Same-cycle writeback forwarding; only matters in the cycle the slot is loaded
  always_comb begin
    wb_live = bus.wb_regwrite & (bus.wb_reg != Xzr);
    opnd_a  = (wb_live && (bus.wb_reg == bus.id_rn)) ? bus.wb_data : bus.id_data1;
    opnd_b  = (wb_live && (bus.wb_reg == bus.id_rm)) ? bus.wb_data : bus.id_data2;
  end
`else
  logic unused_wb;

  assign opnd_a    = bus.id_data1;
  assign opnd_b    = bus.id_data2;
  assign unused_wb = ^{bus.wb_regwrite, bus.wb_reg, bus.wb_data};
`endif

  // Decode slot as it would be captured; an invalid slot never reads or writes
  always_comb begin
    id_slot          = '0;
    id_slot.valid    = bus.id_valid;
    id_slot.memread  = bus.id_valid & bus.id_memread;
    id_slot.regwrite = bus.id_valid & bus.id_regwrite;
    id_slot.rn       = bus.id_rn;
    id_slot.rm       = bus.id_rm;
    id_slot.rd       = bus.id_rd;
    id_slot.a        = opnd_a;
    id_slot.b        = opnd_b;
    id_slot.imm      = bus.id_imm;
    id_slot.ctrl     = bus.id_ctrl;
  end

  // Cycle action in priority order: flush, hold, load-use bubble, load
  always_comb begin
    ex_d          = ex_q;
    cnt_d         = cnt_q;
    bus.stall_out = 1'b0;
    if (bus.ex_flush) begin
      ex_d = '0;
    end else if (bus.ex_hold) begin
      bus.stall_out = 1'b1;
    end else if (load_use) begin
      ex_d          = '0;
      bus.stall_out = 1'b1;
      if (!(&cnt_q)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      ex_d = id_slot;
    end
    // Outputs are quiet while reset is asserted
    if (reset) begin
      bus.stall_out = 1'b0;
    end
  end

  // EX register and bubble counter, synchronously cleared
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_memread  = ex_q.memread;
  assign bus.ex_regwrite = ex_q.regwrite;
  assign bus.ex_rn       = ex_q.rn;
  assign bus.ex_rm       = ex_q.rm;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_a        = ex_q.a;
  assign bus.ex_b        = ex_q.b;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_ctrl     = ex_q.ctrl;
  assign bus.bubble_cnt  = cnt_q;

endmodule
